line_tracker_fsm: RTL
=====================

LINE_TRACKER_FSM -- requirements
Module: line_tracker_fsm

Interface
REQ-001 SHALL have parameter FILT_CYCLES, default 1000: consecutive stable cycles before a sensor pattern is accepted; legal range 1..65535.
REQ-002 SHALL have parameter LOST_TIMEOUT, default 5_000_000: cycles in LOST before recovery (50 ms at 100 MHz).
REQ-003 SHALL have parameter SEARCH_TIMEOUT, default 50_000_000: cycles in SEARCH before HALT.
REQ-004 SHALL have port clk, input, 1 bit: single 100 MHz clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: run request; 0 forces IDLE.
REQ-007 SHALL have port sensor, input, 3 bits: asynchronous IR line sensors {L,C,R}; 1 = line seen.
REQ-008 SHALL have port mode, output, 3 bits: motor command (000 stop, 001 forward, 010 left, 011 right, 110 reverse-left, 111 reverse-right).
REQ-009 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-010 SHALL have port halted, output, 1 bit: high exactly while in HALT.

Function
REQ-011 SHALL pass sensor through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the filtered pattern on the FILT_CYCLES-th consecutive edge at which the synchronized pattern equals the same value differing from filtered; any mismatch restarts the count at 0.
REQ-013 SHALL implement states IDLE=0, FWD=1, LEFT=2, RIGHT=3, LOST=4, SEARCH=5, HALT=6; code 7 SHALL be unreachable and recover to IDLE next edge.
REQ-014 SHALL drive mode as a combinational decode of the state register only: IDLE/HALT 000, FWD 001, LEFT 010, RIGHT 011, LOST 010/011 per last_side, SEARCH 110/111 per last_side.
REQ-015 SHALL, from IDLE/FWD/LEFT/RIGHT/LOST with enable=1, decode filtered: 010 or 111 -> FWD; 110 or 100 -> LEFT; 011 or 001 -> RIGHT; 000 -> LOST (if already LOST, stay); 101 -> hold current state (IDLE holds IDLE).
REQ-016 SHALL set last_side to L on entry to LEFT, R on entry to RIGHT; unchanged otherwise.
REQ-017 SHALL count cycles in LOST from 0 on entry; on count reaching LOST_TIMEOUT-1 with filtered still 000, exit per REQ-027.
REQ-018 SHALL, in SEARCH, leave to the REQ-015 decode target as soon as filtered != 000; else enter HALT after SEARCH_TIMEOUT cycles.
REQ-019 SHALL hold HALT (mode 000) regardless of sensor until enable=0.
REQ-020 SHALL force IDLE and clear all timeout counters on the first edge where enable=0, from any state; filter keeps running.
REQ-021 SHALL have latency from a stable sensor change to mode change of exactly FILT_CYCLES+3 rising edges.
REQ-022 SHALL use 32-bit timeout counters that never wrap; pulses shorter than FILT_CYCLES SHALL never change mode.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state IDLE, mode 000, halted 0, filtered 000, synchronizer flops 000, all counters 0, last_side L.
REQ-024 SHALL resume on the first rising edge after rst_n deasserts; reset mid-turn or mid-search SHALL discard all history.
REQ-025 SHALL guarantee mode=000 throughout reset so the downstream motor stage stops.

Configuration
REQ-026 SHALL provide macro LINE_TRACKER_REVERSE_SEARCH_EN controlling the lost-line recovery path.
REQ-027 SHALL, with the macro defined, go LOST -> SEARCH on timeout; without it, go LOST -> HALT on timeout and omit the SEARCH state logic and counter (code 5 treated as unreachable, recovers to IDLE).

Verification (FILT_CYCLES=4, LOST_TIMEOUT=20, SEARCH_TIMEOUT=40)
REQ-028 SHALL cover: reset, enable=1, sensor=010 held -> mode 000 then 001 exactly 7 edges after sensor change.
REQ-029 SHALL cover: in FWD, sensor=110 for 3 cycles then back to 010 -> mode stays 001 throughout.
REQ-030 SHALL cover: sensor 100 held then 000 -> mode 010 (LOST, last_side L); after 20 cycles mode 110 (macro defined) or 000 with halted=1 (macro undefined).
REQ-031 SHALL cover: in SEARCH, sensor=001 held -> mode 011 after 7 edges; alternatively sensor 000 held 40 cycles -> mode 000, halted=1, then sensor 010 -> still 000.
REQ-032 SHALL cover: in RIGHT, enable dropped 1 cycle -> IDLE, mode 000 next edge; enable re-raised -> RIGHT next edge (filtered retained).
REQ-033 SHALL cover: rst_n pulsed low mid-SEARCH between clock edges -> mode 000 immediately, state_o 0, halted 0.

Source files
------------

// File: rtl/line_tracker_fsm.sv
// line_tracker_fsm: debounced 3-sensor line follower with LOST/SEARCH/HALT recovery.
// Define LINE_TRACKER_REVERSE_SEARCH_EN to add the reverse SEARCH phase after LOST.
module line_tracker_fsm #(
  parameter int unsigned FILT_CYCLES    = 1000,
  parameter int unsigned LOST_TIMEOUT   = 5_000_000,
  parameter int unsigned SEARCH_TIMEOUT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] sensor,
  output logic [2:0] mode,
  output logic [2:0] state_o,
  output logic       halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FWD    = 3'd1;
  localparam logic [2:0] S_LEFT   = 3'd2;
  localparam logic [2:0] S_RIGHT  = 3'd3;
  localparam logic [2:0] S_LOST   = 3'd4;
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
  localparam logic [2:0] S_SEARCH = 3'd5;
  localparam logic [31:0] SRCH_LIM = 32'(SEARCH_TIMEOUT - 1);
`endif
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [15:0] FILT_LIM = 16'(FILT_CYCLES - 1);
  localparam logic [31:0] LOST_LIM = 32'(LOST_TIMEOUT - 1);

  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  filt_q, filt_d;
  logic [2:0]  cand_q, cand_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [2:0]  state_q, state_d;
  logic [31:0] lost_cnt_q, lost_cnt_d;
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
  logic [31:0] srch_cnt_q, srch_cnt_d;
`endif
  logic        side_q, side_d;

  function automatic logic [2:0] decode(
    input logic [2:0] p,
    input logic [2:0] cur
  );
    unique case (p)
      3'b010, 3'b111: decode = S_FWD;
      3'b110, 3'b100: decode = S_LEFT;
      3'b011, 3'b001: decode = S_RIGHT;
      3'b000:         decode = S_LOST;
      default:        decode = cur;
    endcase
  endfunction

  // A new candidate only counts from the edge after a mismatch.
  always_comb begin
    filt_d = filt_q;
    cand_d = cand_q;
    fcnt_d = fcnt_q;
    if (sync2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == '0 || sync2_q == cand_q) begin
      cand_d = sync2_q;
      if (fcnt_q == FILT_LIM) begin
        filt_d = sync2_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 16'd1;
      end
    end else begin
      cand_d = sync2_q;
      fcnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    lost_cnt_d = '0;
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
    srch_cnt_d = '0;
`endif
    side_d     = side_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_FWD, S_LEFT, S_RIGHT:
          state_d = decode(filt_q, state_q);
        S_LOST:
          if (filt_q != 3'b000) begin
            state_d = decode(filt_q, state_q);
          end else if (lost_cnt_q == LOST_LIM) begin
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
            state_d = S_SEARCH;
`else
            state_d = S_HALT;
`endif
          end else begin
            lost_cnt_d = lost_cnt_q + 32'd1;
          end
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
        S_SEARCH:
          if (filt_q != 3'b000) begin
            state_d = decode(filt_q, state_q);
          end else if (srch_cnt_q == SRCH_LIM) begin
            state_d = S_HALT;
          end else begin
            srch_cnt_d = srch_cnt_q + 32'd1;
          end
`endif
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_LEFT && state_q != S_LEFT) side_d = 1'b0;
    if (state_d == S_RIGHT && state_q != S_RIGHT) side_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      cand_q     <= '0;
      fcnt_q     <= '0;
      state_q    <= S_IDLE;
      lost_cnt_q <= '0;
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
      srch_cnt_q <= '0;
`endif
      side_q     <= 1'b0;
    end else begin
      sync1_q    <= sensor;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      cand_q     <= cand_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      lost_cnt_q <= lost_cnt_d;
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
      srch_cnt_q <= srch_cnt_d;
`endif
      side_q     <= side_d;
    end
  end

  // side_q: 0 = line last seen on the left, 1 = right.
  always_comb begin
    unique case (state_q)
      S_FWD:    mode = 3'b001;
      S_LEFT:   mode = 3'b010;
      S_RIGHT:  mode = 3'b011;
      S_LOST:   mode = {2'b01, side_q};
`ifdef LINE_TRACKER_REVERSE_SEARCH_EN
      S_SEARCH: mode = {2'b11, side_q};
`endif
      default:  mode = 3'b000;
    endcase
  end

  assign state_o = state_q;
  assign halted  = (state_q == S_HALT);

endmodule
